load_store_unit: RTL and testbench

//  Sits between the ALU result/rs2 path and the data memory, driving the writeback mux input.

---
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: runs one RISC-V B/H/W load or store over a word-addressed req/ack bus.
// It generates byte enables, replicates store data across lanes, extends load data, and reports faults.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_op_valid,
    input  logic        i_op_write,
    input  logic [2:0]  i_op_funct3,
    input  logic [31:0] i_op_addr,
    input  logic [31:0] i_op_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_ld_valid,
    output logic [31:0] o_ld_data,
    output logic        o_fault,
    output logic [1:0]  o_fault_cause,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_FAULT} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_write;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;
    logic          r_done;
    logic          r_ld_valid;
    logic [31:0]   r_ld_data;
    logic          r_fault;
    logic [1:0]    r_cause;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [3:0]    r_mem_be;
    logic [31:0]   r_mem_wdata;

    logic          w_illegal;
    logic          w_misalign;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ld_ext;

    assign w_illegal  = (i_op_funct3 == 3'b011) || (i_op_funct3 == 3'b110) ||
                        (i_op_funct3 == 3'b111);
    assign w_misalign = ((i_op_funct3[1:0] == 2'b01) && i_op_addr[0]) ||
                        ((i_op_funct3[1:0] == 2'b10) && (i_op_addr[1:0] != 2'b00));

    // Size comes from funct3[1:0]; loads always read the full word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_op_wdata;
        if (i_op_write) begin
            case (i_op_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << i_op_addr[1:0];
                    w_wdata = {4{i_op_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = i_op_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_op_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_ext = {24'd0, w_byte};
            3'b101:  w_ld_ext = {16'd0, w_half};
            default: w_ld_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_done      <= 1'b0;
            r_ld_valid  <= 1'b0;
            r_ld_data   <= 32'd0;
            r_fault     <= 1'b0;
            r_cause     <= 2'b00;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'd0;
        end else begin
            r_done     <= 1'b0;
            r_ld_valid <= 1'b0;
            r_fault    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_op_valid) begin
                        if (w_illegal) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_cause <= 2'b11;
                        end else if (w_misalign) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_cause <= 2'b01;
                        end else begin
                            r_state     <= S_ACCESS;
                            r_cnt       <= '0;
                            r_write     <= i_op_write;
                            r_funct3    <= i_op_funct3;
                            r_off       <= i_op_addr[1:0];
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= i_op_write;
                            r_mem_addr  <= {i_op_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack on the last allowed cycle still completes the access.
                    if (i_mem_ack) begin
                        r_state    <= S_DONE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_done     <= 1'b1;
                        r_ld_valid <= ~r_write;
                        if (!r_write) r_ld_data <= w_ld_ext;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state   <= S_FAULT;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_fault   <= 1'b1;
                        r_cause   <= 2'b10;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_FAULT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall       = ((r_state == S_IDLE) && i_op_valid) || (r_state == S_ACCESS);
    assign o_done        = r_done;
    assign o_ld_valid    = r_ld_valid;
    assign o_ld_data     = r_ld_data;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_cause;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_be      = r_mem_be;
    assign o_mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset corner cases, and random ops against a reference model.
module tb_load_store_unit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_write;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr, op_wdata;
    logic        stall, done, ld_valid, fault;
    logic [31:0] ld_data;
    logic [1:0]  fault_cause;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_op_valid(op_valid), .i_op_write(op_write), .i_op_funct3(op_funct3),
        .i_op_addr(op_addr), .i_op_wdata(op_wdata),
        .o_stall(stall), .o_done(done), .o_ld_valid(ld_valid), .o_ld_data(ld_data),
        .o_fault(fault), .o_fault_cause(fault_cause),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          stall_n, req_n;
        logic        done, ldv, fault, extra;
        logic [1:0]  cause;
        logic [31:0] ld, addr, wdata;
        logic [3:0]  be;
        logic        we;
    } res_t;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a, d, rd;
        int          wt;
        logic        ef;
        logic [1:0]  ec;
        logic [31:0] eld;
        int          es, er;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewd;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Drives one op and records what the DUT did; wt = req cycle carrying the ack (0 = never).
    task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int wt,
                          input logic spur, output res_t r);
        int cyc;
        bit fin;
        r = '{default: 0};
        @(posedge clk); #1;
        op_valid = 1'b1; op_write = w; op_funct3 = f3; op_addr = a; op_wdata = d;
        mem_ack = spur; mem_rdata = $urandom;
        fin = 0; cyc = 0;
        while (!fin && cyc < 4 * TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (stall) r.stall_n++;
            if (mem_req) begin
                r.req_n++;
                r.addr = mem_addr; r.be = mem_be; r.we = mem_we; r.wdata = mem_wdata;
            end
            if (done || fault) begin
                fin = 1;
                r.done = done; r.ldv = ld_valid; r.fault = fault;
                r.cause = fault_cause; r.ld = ld_data;
            end
            mem_ack   = mem_req && (r.req_n == wt);
            mem_rdata = mem_ack ? rd : $urandom;
            if (!stall) op_valid = 1'b0;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL op_bound: no done/fault within %0d cycles", cyc);
        end
        mem_ack = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        r.extra = done | fault | ld_valid | mem_req;
    endtask

    task automatic check_res(input string tag, input res_t r, input logic w, input logic ef,
                             input logic [1:0] ec, input logic [31:0] eld, input int es,
                             input int er, input logic [31:0] eaddr, input logic [3:0] ebe,
                             input logic [31:0] ewd);
        chk({tag, ".done"}, r.done, !ef);
        chk({tag, ".fault"}, r.fault, ef);
        chk({tag, ".ld_valid"}, r.ldv, !ef && !w);
        chk({tag, ".cause"}, r.cause, ec);
        chk({tag, ".ld_data"}, r.ld, eld);
        chk({tag, ".stall_cycles"}, r.stall_n, es);
        chk({tag, ".req_cycles"}, r.req_n, er);
        chk({tag, ".pulse_width"}, r.extra, 0);
        if (er > 0) begin
            chk({tag, ".addr"}, r.addr, eaddr);
            chk({tag, ".be"}, r.be, ebe);
            chk({tag, ".we"}, r.we, w);
            if (w) chk({tag, ".wdata"}, r.wdata, ewd);
        end
    endtask

    initial begin
        res_t r;
        logic seen;
        logic [31:0] m_ld;
        logic [1:0]  m_cause;

        vt[0]  = '{0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 3, 0, 2'd0, 32'hDEADBEEF, 4, 3, 32'h100, 4'hF, 0};
        vt[1]  = '{0, 3'd0, 32'h103, 0, 32'h80FF0000, 1, 0, 2'd0, 32'hFFFFFF80, 2, 1, 32'h100, 4'hF, 0};
        vt[2]  = '{0, 3'd4, 32'h103, 0, 32'h80FF0000, 2, 0, 2'd0, 32'h00000080, 3, 2, 32'h100, 4'hF, 0};
        vt[3]  = '{1, 3'd1, 32'h202, 32'h1234ABCD, 0, 1, 0, 2'd0, 32'h80, 2, 1, 32'h200, 4'hC, 32'hABCDABCD};
        vt[4]  = '{0, 3'd2, 32'h101, 0, 0, 1, 1, 2'd1, 32'h80, 1, 0, 0, 0, 0};
        vt[5]  = '{0, 3'd3, 32'h40, 0, 0, 1, 1, 2'd3, 32'h80, 1, 0, 0, 0, 0};
        vt[6]  = '{0, 3'd1, 32'h6, 0, 32'h80011234, 1, 0, 2'd3, 32'hFFFF8001, 2, 1, 32'h4, 4'hF, 0};
        vt[7]  = '{0, 3'd5, 32'h4, 0, 32'h80019234, 2, 0, 2'd3, 32'h00009234, 3, 2, 32'h4, 4'hF, 0};
        vt[8]  = '{1, 3'd0, 32'h5, 32'hFFFF12CD, 0, 1, 0, 2'd3, 32'h9234, 2, 1, 32'h4, 4'h2, 32'hCDCDCDCD};
        vt[9]  = '{1, 3'd2, 32'hC, 32'hCAFEF00D, 0, 4, 0, 2'd3, 32'h9234, 5, 4, 32'hC, 4'hF, 32'hCAFEF00D};
        vt[10] = '{0, 3'd1, 32'h3, 0, 0, 1, 1, 2'd1, 32'h9234, 1, 0, 0, 0, 0};
        vt[11] = '{1, 3'd7, 32'h3, 0, 0, 1, 1, 2'd3, 32'h9234, 1, 0, 0, 0, 0};
        vt[12] = '{0, 3'd2, 32'h10, 0, 0, 0, 1, 2'd2, 32'h9234, TIMEOUT + 1, TIMEOUT, 32'h10, 4'hF, 0};
        vt[13] = '{0, 3'd0, 32'h1, 0, 32'h00007F00, TIMEOUT, 0, 2'd2, 32'h7F, TIMEOUT + 1, TIMEOUT, 32'h0, 4'hF, 0};

        rst = 1'b1; op_valid = 0; op_write = 0; op_funct3 = 0; op_addr = 0; op_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("reset.stall", stall, 0);
        chk("reset.done", done, 0);
        chk("reset.ld_valid", ld_valid, 0);
        chk("reset.ld_data", ld_data, 0);
        chk("reset.fault", fault, 0);
        chk("reset.cause", fault_cause, 0);
        chk("reset.mem_req", mem_req, 0);
        chk("reset.mem_we", mem_we, 0);
        chk("reset.mem_addr", mem_addr, 0);
        chk("reset.mem_be", mem_be, 0);
        chk("reset.mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].w, vt[i].f3, vt[i].a, vt[i].d, vt[i].rd, vt[i].wt, logic'(i % 2), r);
            check_res($sformatf("vec%0d", i), r, vt[i].w, vt[i].ef, vt[i].ec, vt[i].eld,
                      vt[i].es, vt[i].er, vt[i].eaddr, vt[i].ebe, vt[i].ewd);
        end

        // Reset in the middle of an access, then a late ack that must be ignored.
        @(posedge clk); #1;
        op_valid = 1; op_write = 0; op_funct3 = 3'd2; op_addr = 32'h40;
        @(posedge clk); #1;
        op_valid = 0;
        @(posedge clk); #1;
        chk("rstmid.req_before", mem_req, 1);
        #2 rst = 1'b1;
        #1 chk("rstmid.req_async", mem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen = seen | done | ld_valid | fault | mem_req;
            mem_ack = 1'b0;
        end
        chk("rstmid.no_pulse", seen, 0);
        chk("rstmid.ld_data", ld_data, 0);
        chk("rstmid.cause", fault_cause, 0);

        m_ld = 0; m_cause = 0;
        for (int n = 0; n < 120; n++) begin
            logic w, illegal, misal, to;
            logic [2:0] f3;
            logic [31:0] a, d, rd, v, eaddr, ewd;
            logic [3:0] ebe;
            int size, bits, wt, es, er;
            w = logic'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: f3 = 3'd0;  1: f3 = 3'd1;  2: f3 = 3'd2;  3: f3 = 3'd2;
                4: f3 = w ? 3'd0 : 3'd4;  5: f3 = w ? 3'd1 : 3'd5;
                6: f3 = 3'(2 + $urandom_range(0, 1) * 4 + $urandom_range(0, 1));
                default: f3 = 3'd2;
            endcase
            if (f3 == 3'd2 && $urandom_range(0, 9) == 0) f3 = 3'd3;
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'd1) ? {a[1], 1'b0} :
                                                     (f3[1:0] == 2'd2) ? 2'b00 : a[1:0];
            d  = $urandom;
            rd = $urandom;
            case ($urandom_range(0, 15))
                0:       wt = 0;
                1:       wt = TIMEOUT;
                default: wt = $urandom_range(1, 6);
            endcase

            size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            misal   = !illegal && ((a % size) != 0);
            to      = !illegal && !misal && (wt == 0);
            eaddr   = a & ~32'd3;
            ebe     = w ? 4'(((1 << size) - 1) << (a % 4)) : 4'hF;
            ewd     = (size == 1) ? d[7:0] * 32'h01010101 :
                      (size == 2) ? d[15:0] * 32'h00010001 : d;
            if (illegal || misal) begin
                es = 1; er = 0;
                m_cause = illegal ? 2'd3 : 2'd1;
            end else if (to) begin
                es = TIMEOUT + 1; er = TIMEOUT;
                m_cause = 2'd2;
            end else begin
                es = wt + 1; er = wt;
                if (!w) begin
                    bits = 8 * size;
                    v = rd >> (8 * (a % 4));
                    if (size < 4) begin
                        v = v & ((32'd1 << bits) - 1);
                        if (!f3[2] && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
                    end
                    m_ld = v;
                end
            end
            run_op(w, f3, a, d, rd, wt, logic'($urandom_range(0, 1)), r);
            check_res($sformatf("rnd%0d", n), r, w, illegal || misal || to, m_cause, m_ld,
                      es, er, eaddr, ebe, ewd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_bound: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
